// File: rtl/glb_psum_pkg.sv
// rtl/glb_psum_pkg.sv - shared types for the psum global-buffer sequencer
// Contents:
//   op_e        command opcodes carried on cmd_op
//   state_e     sequencer states
//   op_to_state maps an accepted opcode to the state that executes it
package glb_psum_pkg;

  typedef enum logic [1:0] {
    OP_CLEAR = 2'd0,
    OP_ACCUM = 2'd1,
    OP_DRAIN = 2'd2,
    OP_NOP   = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ACCUM = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // OP_NOP has no work phase, so it goes straight to the completion state.
  function automatic state_e op_to_state(input op_e op);
    state_e s;
    case (op)
      OP_CLEAR: s = S_CLEAR;
      OP_ACCUM: s = S_ACCUM;
      OP_DRAIN: s = S_DRAIN;
      default:  s = S_DONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/glb_psum_skid_fifo.sv
// rtl/glb_psum_skid_fifo.sv - 2-entry skid buffer between GLB read data and the drain stream
// Ports:
//   clk, reset            clock, synchronous active-high reset (empties the buffer)
//   push, push_data       write one word (ignored when full)
//   pop                   retire the head word (ignored when empty)
//   head_data             oldest stored word
//   full, empty, count    occupancy status
module psum_skid_fifo
  import glb_psum_pkg::*;
#(
  parameter int DATA_BITWIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_BITWIDTH-1:0] push_data,
  input  logic                     pop,
  output logic [DATA_BITWIDTH-1:0] head_data,
  output logic                     full,
  output logic                     empty,
  output logic [1:0]               count
);

  logic [DATA_BITWIDTH-1:0] mem [2];
  logic                     wr_ptr;
  logic                     rd_ptr;
  logic                     do_push;
  logic                     do_pop;

  assign full      = (count == 2'd2);
  assign empty     = (count == 2'd0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr];

  // Storage carries no reset; only the pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/glb_psum_ctrl.sv
// rtl/glb_psum_ctrl.sv - CLEAR / ACCUM / DRAIN sequencer and sole master of a GLB psum bank
// Ports:
//   clk, reset                               clock, synchronous active-high reset
//   cmd_valid/cmd_ready/cmd_op/cmd_base/cmd_len  command handshake (accepted only in idle)
//   psum_in_valid/psum_in_ready/psum_in_data     ACCUM input stream
//   psum_out_valid/psum_out_ready/psum_out_data  DRAIN output stream
//   glb_read_req/glb_r_addr/glb_r_data       bank read port (data returns one cycle later)
//   glb_write_en/glb_w_addr/glb_w_data       bank write port
//   busy, done                               status; done pulses for one cycle per command
module glb_psum_ctrl
  import glb_psum_pkg::*;
#(
  parameter int DATA_BITWIDTH = 16,
  parameter int ADDR_BITWIDTH = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [ADDR_BITWIDTH-1:0] cmd_base,
  input  logic [ADDR_BITWIDTH:0]   cmd_len,
  input  logic                     psum_in_valid,
  output logic                     psum_in_ready,
  input  logic [DATA_BITWIDTH-1:0] psum_in_data,
  output logic                     psum_out_valid,
  input  logic                     psum_out_ready,
  output logic [DATA_BITWIDTH-1:0] psum_out_data,
  output logic                     glb_read_req,
  output logic [ADDR_BITWIDTH-1:0] glb_r_addr,
  input  logic [DATA_BITWIDTH-1:0] glb_r_data,
  output logic                     glb_write_en,
  output logic [ADDR_BITWIDTH-1:0] glb_w_addr,
  output logic [DATA_BITWIDTH-1:0] glb_w_data,
  output logic                     busy,
  output logic                     done
);

  localparam logic [ADDR_BITWIDTH:0] LEN_ONE = {{ADDR_BITWIDTH{1'b0}}, 1'b1};

  state_e                   state;
  logic [ADDR_BITWIDTH-1:0] base_q;
  logic [ADDR_BITWIDTH:0]   len_q;
  // cnt_q: words written (CLEAR), accepted (ACCUM) or read-issued (DRAIN)
  logic [ADDR_BITWIDTH:0]   cnt_q;
  logic [ADDR_BITWIDTH:0]   out_cnt_q;

  // ACCUM stage 1: the word accepted last cycle, waiting for its bank read data
  logic                     s1_valid_q;
  logic [ADDR_BITWIDTH-1:0] s1_addr_q;
  logic [DATA_BITWIDTH-1:0] s1_data_q;

  // DRAIN: a read issued last cycle whose data is on glb_r_data now
  logic                     rd_pend_q;

  logic                     cmd_fire;
  logic                     in_fire;
  logic                     out_fire;
  logic [ADDR_BITWIDTH-1:0] cur_addr;
  logic                     drain_issue;
  logic [2:0]               drain_cost;

  logic                     f_pop;
  logic [DATA_BITWIDTH-1:0] f_head;
  logic                     f_full;
  logic                     f_empty;
  logic [1:0]               f_count;

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign done      = !reset && (state == S_DONE);
  assign cmd_fire  = cmd_valid && cmd_ready;

  // Window addressing wraps naturally through the ADDR_BITWIDTH-wide add.
  assign cur_addr = base_q + cnt_q[ADDR_BITWIDTH-1:0];

  assign psum_in_ready = !reset && (state == S_ACCUM) && (cnt_q < len_q);
  assign in_fire       = psum_in_valid && psum_in_ready;

  assign psum_out_valid = !reset && (state == S_DRAIN) && !f_empty;
  assign psum_out_data  = psum_out_valid ? f_head : '0;
  assign out_fire       = psum_out_valid && psum_out_ready;
  assign f_pop          = out_fire;

  // Words committed to the buffer: the one in flight plus those stored, less
  // the one leaving this cycle. Crediting the pop keeps a full-rate stream
  // while the buffer can never be asked to hold a third word.
  assign drain_cost  = {2'b00, rd_pend_q} + {1'b0, f_count} - {2'b00, f_pop};
  assign drain_issue = !reset && (state == S_DRAIN) && (cnt_q < len_q) &&
                       (drain_cost < 3'd2) && !(f_full && !f_pop);

  assign glb_read_req = in_fire || drain_issue;
  assign glb_r_addr   = glb_read_req ? cur_addr : '0;

  always_comb begin
    glb_write_en = 1'b0;
    glb_w_addr   = '0;
    glb_w_data   = '0;
    if (!reset) begin
      if (state == S_CLEAR) begin
        glb_write_en = 1'b1;
        glb_w_addr   = cur_addr;
      end else if ((state == S_ACCUM) && s1_valid_q) begin
        // Two's-complement wrap on overflow; no saturation.
        glb_write_en = 1'b1;
        glb_w_addr   = s1_addr_q;
        glb_w_data   = glb_r_data + s1_data_q;
      end
    end
  end

  psum_skid_fifo #(
    .DATA_BITWIDTH(DATA_BITWIDTH)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (rd_pend_q),
    .push_data (glb_r_data),
    .pop       (f_pop),
    .head_data (f_head),
    .full      (f_full),
    .empty     (f_empty),
    .count     (f_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      out_cnt_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_data_q  <= '0;
      rd_pend_q  <= 1'b0;
    end else begin
      s1_valid_q <= 1'b0;
      rd_pend_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_fire) begin
            base_q    <= cmd_base;
            len_q     <= cmd_len;
            cnt_q     <= '0;
            out_cnt_q <= '0;
            if ((cmd_len == '0) || (op_e'(cmd_op) == OP_NOP)) begin
              state <= S_DONE;
            end else begin
              state <= op_to_state(op_e'(cmd_op));
            end
          end
        end
        S_CLEAR: begin
          cnt_q <= cnt_q + LEN_ONE;
          if (cnt_q == len_q - LEN_ONE) begin
            state <= S_DONE;
          end
        end
        S_ACCUM: begin
          if (in_fire) begin
            cnt_q      <= cnt_q + LEN_ONE;
            s1_valid_q <= 1'b1;
            s1_addr_q  <= cur_addr;
            s1_data_q  <= psum_in_data;
          end
          // All words accepted and the final one is being written now.
          if (s1_valid_q && (cnt_q == len_q)) begin
            state <= S_DONE;
          end
        end
        S_DRAIN: begin
          if (drain_issue) begin
            cnt_q     <= cnt_q + LEN_ONE;
            rd_pend_q <= 1'b1;
          end
          if (out_fire) begin
            out_cnt_q <= out_cnt_q + LEN_ONE;
            if (out_cnt_q == len_q - LEN_ONE) begin
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_glb_psum_ctrl.sv
// tb/tb_glb_psum_ctrl.sv - self-checking bench for glb_psum_ctrl with a behavioural bank and window model
module tb_glb_psum_ctrl;
  import glb_psum_pkg::*;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int DEPTH = 1024;
  localparam int MAXC = 4000;

  logic clk = 1'b0;
  logic reset;
  logic cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [AW-1:0] cmd_base;
  logic [AW:0] cmd_len;
  logic psum_in_valid, psum_in_ready;
  logic [DW-1:0] psum_in_data;
  logic psum_out_valid, psum_out_ready;
  logic [DW-1:0] psum_out_data;
  logic glb_read_req, glb_write_en;
  logic [AW-1:0] glb_r_addr, glb_w_addr;
  logic [DW-1:0] glb_r_data, glb_w_data;
  logic busy, done;

  always #5 clk = ~clk;

  glb_psum_ctrl #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_base(cmd_base), .cmd_len(cmd_len),
    .psum_in_valid(psum_in_valid), .psum_in_ready(psum_in_ready), .psum_in_data(psum_in_data),
    .psum_out_valid(psum_out_valid), .psum_out_ready(psum_out_ready), .psum_out_data(psum_out_data),
    .glb_read_req(glb_read_req), .glb_r_addr(glb_r_addr), .glb_r_data(glb_r_data),
    .glb_write_en(glb_write_en), .glb_w_addr(glb_w_addr), .glb_w_data(glb_w_data),
    .busy(busy), .done(done)
  );

  // Bank: 1R1W, registered read, sentinel when not read, writes ignored in reset.
  logic [DW-1:0] bank [0:DEPTH-1];
  logic [DW-1:0] r_data_q;
  always @(posedge clk) begin
    if (!reset && glb_write_en) bank[glb_w_addr] <= glb_w_data;
    r_data_q <= glb_read_req ? bank[glb_r_addr] : 16'hBAD0;
  end
  assign glb_r_data = r_data_q;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] ref_mem [0:DEPTH-1];
  logic [DW-1:0] in_q[$];
  logic [DW-1:0] out_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] wd_q[$];
  int wa_q[$];
  int rd_cnt, done_cnt, done_cyc, first_valid, last_out, credit_viol, illegal;
  logic after_done, after_ready;

  function automatic int wrap(input int a);
    return a % DEPTH;
  endfunction

  function automatic void model_clear(input int base, input int len);
    for (int i = 0; i < len; i++) ref_mem[wrap(base + i)] = '0;
  endfunction

  function automatic void model_accum(input int base);
    for (int i = 0; i < in_q.size(); i++) ref_mem[wrap(base + i)] = ref_mem[wrap(base + i)] + in_q[i];
  endfunction

  function automatic void model_expect(input int base, input int len);
    exp_q.delete();
    for (int i = 0; i < len; i++) exp_q.push_back(ref_mem[wrap(base + i)]);
  endfunction

  function automatic logic rdy_for(input int k, input int mode);
    logic [6:0] pat;
    pat = 7'b1011001;  // 1,0,0,1,1,0,1 from bit 0 upward
    if (mode == 0) return 1'b1;
    if (mode == 1) return pat[(k - 1) % 7];
    return 1'($urandom_range(0, 1));
  endfunction

  // Issue one command and drive its streams until done; records observations.
  // Cycle k=1 is the first cycle after the accepting edge.
  task automatic run_cmd(input logic [1:0] op, input int base, input int len,
                         input int in_mode, input int rdy_mode);
    int in_idx, issued, outs;
    logic in_fire, out_fire, saw_done;
    out_q.delete(); wa_q.delete(); wd_q.delete();
    rd_cnt = 0; done_cnt = 0; done_cyc = -1; first_valid = -1; last_out = -1;
    credit_viol = 0; illegal = 0; in_idx = 0; issued = 0; outs = 0;
    cmd_op = op; cmd_base = base[AW-1:0]; cmd_len = len[AW:0]; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int k = 1; k <= MAXC; k++) begin
      if (!psum_in_valid && in_idx < in_q.size() && (in_mode == 0 || $urandom_range(0, 1) == 1)) begin
        psum_in_valid = 1'b1;
        psum_in_data = in_q[in_idx];
      end
      psum_out_ready = rdy_for(k, rdy_mode);
      @(negedge clk);
      in_fire = psum_in_valid && psum_in_ready;
      out_fire = psum_out_valid && psum_out_ready;
      if (glb_write_en) begin wa_q.push_back(int'(glb_w_addr)); wd_q.push_back(glb_w_data); end
      if (glb_read_req) begin rd_cnt++; issued++; end
      if (psum_out_valid && first_valid < 0) first_valid = k;
      if (out_fire) begin out_q.push_back(psum_out_data); outs++; last_out = k; end
      if (op == 2'd2 && issued - outs > 2) credit_viol++;
      if ((op != 2'd1 && psum_in_ready) || (op != 2'd2 && psum_out_valid) ||
          (op == 2'd0 && glb_read_req) || (op == 2'd2 && glb_write_en) ||
          ((op == 2'd3 || len == 0) && (glb_read_req || glb_write_en)) ||
          !busy || cmd_ready)
        illegal++;
      saw_done = done;
      if (done) begin done_cnt++; done_cyc = k; end
      @(posedge clk); #1;
      if (in_fire) begin in_idx++; psum_in_valid = 1'b0; end
      if (saw_done) break;
    end
    psum_in_valid = 1'b0;
    psum_out_ready = 1'b0;
    @(negedge clk);
    after_done = done;
    after_ready = cmd_ready;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    cmd_valid = 0; cmd_op = 0; cmd_base = 0; cmd_len = 0;
    psum_in_valid = 0; psum_in_data = 0; psum_out_ready = 0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({glb_write_en, glb_read_req, done} !== 3'b000) begin
      errors++; $display("FAIL reset_strobes: got %b expected 000", {glb_write_en, glb_read_req, done});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({cmd_ready, busy, done, psum_in_ready, psum_out_valid, glb_read_req, glb_write_en} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_state: got %b expected 1000000",
               {cmd_ready, busy, done, psum_in_ready, psum_out_valid, glb_read_req, glb_write_en});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_full_clear();
    in_q.delete();
    run_cmd(2'd0, 0, DEPTH, 0, 0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    checks++;
    if (wa_q.size() != DEPTH || done_cyc != DEPTH + 1) begin
      errors++; $display("FAIL full_clear: got %0d writes done at %0d expected %0d writes done at %0d",
                         wa_q.size(), done_cyc, DEPTH, DEPTH + 1);
    end
    checks++;
    if (after_done !== 1'b0 || after_ready !== 1'b1) begin
      errors++; $display("FAIL done_pulse_width: got done=%b ready=%b expected done=0 ready=1", after_done, after_ready);
    end
  endtask

  task automatic test_clear();
    int bad;
    in_q.delete();
    for (int i = 0; i < 8; i++) in_q.push_back(16'd7);
    run_cmd(2'd1, 0, 8, 0, 0);  // preload 0..7 with 7s on the cleared bank
    model_accum(0);
    in_q.delete();
    run_cmd(2'd0, 0, 4, 0, 0);
    model_clear(0, 4);
    bad = 0;
    for (int i = 0; i < 4; i++) if (i >= wa_q.size() || wa_q[i] != i || wd_q[i] !== 16'd0) bad++;
    checks++;
    if (bad != 0 || wa_q.size() != 4) begin
      errors++; $display("FAIL clear_writes: got %0d writes (%0d wrong) expected 4 zeros at 0..3", wa_q.size(), bad);
    end
    checks++;
    if (done_cyc != 5 || done_cnt != 1 || rd_cnt != 0) begin
      errors++; $display("FAIL clear_timing: got done at %0d reads %0d expected done at 5 reads 0", done_cyc, rd_cnt);
    end
    model_expect(0, 8);
    run_cmd(2'd2, 0, 8, 0, 0);
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++) if (i >= out_q.size() || out_q[i] !== exp_q[i]) bad++;
    checks++;
    if (bad != 0 || out_q.size() != 8) begin
      errors++; $display("FAIL clear_drain_data: got %0d words (%0d wrong) expected 0,0,0,0,7,7,7,7", out_q.size(), bad);
    end
    checks++;
    if (first_valid != 3 || last_out != 10 || done_cyc != 11) begin
      errors++; $display("FAIL drain_latency: got first=%0d last=%0d done=%0d expected 3 10 11",
                         first_valid, last_out, done_cyc);
    end
  endtask

  task automatic test_accum();
    int bad;
    in_q.delete();
    run_cmd(2'd0, 0, 4, 0, 0);
    model_clear(0, 4);
    for (int r = 0; r < 2; r++) begin
      in_q = '{16'd1, 16'd2, 16'd3, 16'd4};
      run_cmd(2'd1, 0, 4, 0, 0);
      model_accum(0);
      checks++;
      if (wa_q.size() != 4 || done_cyc != 6 || rd_cnt != 4) begin
        errors++; $display("FAIL accum_timing: got writes=%0d reads=%0d done=%0d expected 4 4 6", wa_q.size(), rd_cnt, done_cyc);
      end
    end
    in_q.delete();
    exp_q = '{16'd2, 16'd4, 16'd6, 16'd8};
    run_cmd(2'd2, 0, 4, 0, 0);
    bad = 0;
    for (int i = 0; i < 4; i++) if (i >= out_q.size() || out_q[i] !== exp_q[i]) bad++;
    checks++;
    if (bad != 0 || out_q.size() != 4) begin
      errors++; $display("FAIL accum_drain: got %0d words (%0d wrong) expected 2,4,6,8", out_q.size(), bad);
    end
  endtask

  task automatic test_accum_wrap();
    int bad;
    in_q.delete();
    run_cmd(2'd0, 1022, 4, 0, 0);
    model_clear(1022, 4);
    for (int r = 0; r < 2; r++) begin
      in_q = '{16'h7FFF, 16'd1, 16'd2, 16'd3};
      run_cmd(2'd1, 1022, 4, 1, 0);
      model_accum(1022);
    end
    checks++;
    if (wa_q.size() != 4 || wa_q[0] != 1022 || wa_q[1] != 1023 || wa_q[2] != 0 || wa_q[3] != 1) begin
      errors++; $display("FAIL wrap_addr: got %0d writes first %0d expected 1022,1023,0,1",
                         wa_q.size(), (wa_q.size() > 0) ? wa_q[0] : -1);
    end
    in_q.delete();
    exp_q = '{16'hFFFE, 16'd2, 16'd4, 16'd6};
    run_cmd(2'd2, 1022, 4, 0, 0);
    bad = 0;
    for (int i = 0; i < 4; i++) if (i >= out_q.size() || out_q[i] !== exp_q[i]) bad++;
    checks++;
    if (bad != 0 || out_q.size() != 4) begin
      errors++; $display("FAIL wrap_data: got %0d words (%0d wrong) first %h expected fffe,2,4,6",
                         out_q.size(), bad, (out_q.size() > 0) ? out_q[0] : 16'h0);
    end
  endtask

  task automatic test_drain_backpressure();
    int bad;
    in_q.delete();
    for (int i = 0; i < 8; i++) in_q.push_back(16'($urandom));
    run_cmd(2'd1, 100, 8, 1, 0);
    model_accum(100);
    in_q.delete();
    model_expect(100, 8);
    run_cmd(2'd2, 100, 8, 0, 1);
    bad = 0;
    for (int i = 0; i < 8; i++) if (i >= out_q.size() || out_q[i] !== exp_q[i]) bad++;
    checks++;
    if (bad != 0 || out_q.size() != 8) begin
      errors++; $display("FAIL bp_data: got %0d words (%0d wrong) expected 8 in order", out_q.size(), bad);
    end
    checks++;
    if (credit_viol != 0 || rd_cnt != 8 || illegal != 0) begin
      errors++; $display("FAIL bp_reads: got viol=%0d reads=%0d illegal=%0d expected 0 8 0", credit_viol, rd_cnt, illegal);
    end
  endtask

  task automatic test_len_zero();
    in_q.delete();
    for (int op = 0; op < 5; op++) begin
      run_cmd(op[1:0] | ((op == 4) ? 2'd3 : 2'd0), $urandom_range(0, DEPTH - 1), (op == 4) ? 5 : 0, 0, 0);
      checks++;
      if (done_cyc != 1 || rd_cnt != 0 || wa_q.size() != 0 || illegal != 0) begin
        errors++; $display("FAIL zero_len op%0d: got done=%0d reads=%0d writes=%0d illegal=%0d expected 1 0 0 0",
                           op, done_cyc, rd_cnt, wa_q.size(), illegal);
      end
    end
    checks++;
    if (after_done !== 1'b0 || after_ready !== 1'b1) begin
      errors++; $display("FAIL zero_len_pulse: got done=%b ready=%b expected 0 1", after_done, after_ready);
    end
  endtask

  task automatic test_reset_mid_accum();
    int dones;
    cmd_op = 2'd1; cmd_base = 10'd200; cmd_len = 11'd4; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    psum_in_valid = 1'b1; psum_in_data = 16'd5;
    @(negedge clk);
    checks++;
    if (psum_in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b expected 1", psum_in_ready); end
    @(posedge clk); #1;
    psum_in_data = 16'd6;
    @(negedge clk);
    checks++;
    if (glb_write_en !== 1'b1 || glb_w_addr !== 10'd200) begin
      errors++; $display("FAIL mid_write: got en=%b addr=%0d expected 1 200", glb_write_en, glb_w_addr);
    end
    @(posedge clk); #1;
    psum_in_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    checks++;
    if (glb_write_en !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL mid_reset_write: got en=%b done=%b expected 0 0", glb_write_en, done);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done || !cmd_ready || busy) dones++;
      @(posedge clk); #1;
    end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL mid_idle: got %0d non-idle cycles expected 0", dones); end
    in_q.delete();
    run_cmd(2'd0, 200, 4, 0, 0);
    model_clear(200, 4);
    model_expect(200, 6);
    run_cmd(2'd2, 200, 6, 0, 2);
    dones = 0;
    for (int i = 0; i < 6; i++) if (i >= out_q.size() || out_q[i] !== exp_q[i]) dones++;
    checks++;
    if (dones != 0 || out_q.size() != 6 || done_cnt != 1) begin
      errors++; $display("FAIL post_reset_cmd: got %0d words (%0d wrong) done=%0d expected 6 0 1", out_q.size(), dones, done_cnt);
    end
  endtask

  task automatic test_random();
    int op, base, len, bad, exp_w;
    logic [DW-1:0] want;
    for (int n = 0; n < 30; n++) begin
      op = $urandom_range(0, 3); base = $urandom_range(0, DEPTH - 1); len = $urandom_range(0, 12);
      in_q.delete();
      if (op == 1) for (int i = 0; i < len; i++) in_q.push_back(16'($urandom));
      if (op == 2) model_expect(base, len);
      run_cmd(op[1:0], base, len, 1, 2);
      exp_w = ((op == 0 || op == 1) && len > 0) ? len : 0;
      bad = 0;
      if (op == 1)
        for (int i = 0; i < wd_q.size() && i < len; i++) begin
          want = ref_mem[wrap(base + i)] + in_q[i];
          if (wd_q[i] !== want || wa_q[i] != wrap(base + i)) bad++;
        end
      if (op == 2)
        for (int i = 0; i < len; i++) if (i >= out_q.size() || out_q[i] !== exp_q[i]) bad++;
      checks++;
      if (done_cnt != 1 || illegal != 0 || credit_viol != 0 || wa_q.size() != exp_w || bad != 0 ||
          (op == 2 && out_q.size() != len) || after_done !== 1'b0) begin
        errors++;
        $display("FAIL random_cmd %0d op=%0d base=%0d len=%0d: got done=%0d illegal=%0d viol=%0d writes=%0d bad=%0d outs=%0d expected 1 0 0 %0d 0 %0d",
                 n, op, base, len, done_cnt, illegal, credit_viol, wa_q.size(), bad, out_q.size(), exp_w, (op == 2) ? len : 0);
      end
      if (op == 0) model_clear(base, len);
      if (op == 1) model_accum(base);
    end
    in_q.delete();
    model_expect(0, DEPTH);
    run_cmd(2'd2, 0, DEPTH, 0, 2);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (i >= out_q.size() || out_q[i] !== exp_q[i]) bad++;
    checks++;
    if (bad != 0 || out_q.size() != DEPTH || credit_viol != 0) begin
      errors++; $display("FAIL full_drain: got %0d words (%0d wrong) viol=%0d expected %0d 0 0", out_q.size(), bad, credit_viol, DEPTH);
    end
  endtask

  initial begin
    test_reset();
    test_full_clear();
    test_clear();
    test_accum();
    test_accum_wrap();
    test_drain_backpressure();
    test_len_zero();
    test_reset_mid_accum();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
